// File: rtl/uart_pkg.sv
// Shared UART constants used by the receive-side FIFO and its neighbours.
package uart_pkg;

    localparam int UART_DATA_W   = 8;
    localparam int CLOCK_PER_BIT = 10416;
    localparam int BAUD_RATE     = 9600;

endpackage

// File: rtl/uart_rx_fifo_if.sv
// Receiver-to-consumer bus of the UART receive FIFO; the FIFO is the slave side.
interface uart_rx_fifo_if #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16
) ();

    // Producer side has no ready: a byte is offered for one clock on each rising
    // edge of rx_done and is either stored or dropped (overflow). Consumer side is
    // first-word-fall-through: rd_data is valid whenever empty is low, and the head
    // is consumed on a clock where rd_en is high and empty is low.
    logic [DATA_W-1:0]        rx_data;
    logic                     rx_done;
    logic                     rd_en;
    logic                     clr_ovf;
    logic [DATA_W-1:0]        rd_data;
    logic                     empty;
    logic                     full;
    logic [$clog2(DEPTH):0]   count;
    logic                     overflow;
`ifdef UART_RX_FIFO_ALMOST_FULL_EN
    logic                     almost_full;
`endif

    modport master (
        output rx_data, rx_done, rd_en, clr_ovf,
`ifdef UART_RX_FIFO_ALMOST_FULL_EN
        input  almost_full,
`endif
        input  rd_data, empty, full, count, overflow
    );

    modport slave (
        input  rx_data, rx_done, rd_en, clr_ovf,
`ifdef UART_RX_FIFO_ALMOST_FULL_EN
        output almost_full,
`endif
        output rd_data, empty, full, count, overflow
    );

endinterface

// File: rtl/rise_edge_detect.sv
// One-bit rising-edge detector with a registered previous value; reusable for tx_start.
module rise_edge_detect (
    input  logic clk,
    input  logic rst,
    input  logic sig,
    output logic rise
);

    logic prev;
    logic arm;

    // arm masks the first clock after reset so a level held through reset is not an edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            prev <= 1'b0;
            arm  <= 1'b1;
        end else begin
            prev <= sig;
            arm  <= 1'b0;
        end
    end

    assign rise = sig & ~prev & ~arm;

endmodule

// File: rtl/uart_rx_fifo.sv
// FWFT byte FIFO behind the UART receiver with sticky overflow.
// Optional almost_full output enabled by defining UART_RX_FIFO_ALMOST_FULL_EN.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int DATA_W   = UART_DATA_W,
    parameter int DEPTH    = 16,
    parameter int AF_LEVEL = 12
) (
    input  logic           clk,
    input  logic           rst,
    uart_rx_fifo_if.slave  bus
);

    localparam int AW = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW:0]       wptr;
    logic [AW:0]       rptr;
    logic [AW:0]       count_q;
    logic [AW:0]       count_next;
    logic              ovf_q;
    logic              push;
    logic              pop;
    logic              wr;
    logic              drop;
    logic              empty_w;
    logic              full_w;

    rise_edge_detect u_push_edge (
        .clk  (clk),
        .rst  (rst),
        .sig  (bus.rx_done),
        .rise (push)
    );

    assign empty_w = (count_q == '0);
    assign full_w  = (count_q == (AW+1)'(DEPTH));
    assign pop     = bus.rd_en & ~empty_w;
    // A pop in the same clock frees the head slot, so a push at full still lands.
    assign wr      = push & (~full_w | pop);
    assign drop    = push & full_w & ~pop;

    always_comb begin
        count_next = count_q;
        case ({wr, pop})
            2'b10:   count_next = count_q + 1'b1;
            2'b01:   count_next = count_q - 1'b1;
            default: count_next = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr    <= '0;
            rptr    <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            if (wr)  wptr <= wptr + 1'b1;
            if (pop) rptr <= rptr + 1'b1;
            count_q <= count_next;
            if (drop)             ovf_q <= 1'b1;
            else if (bus.clr_ovf) ovf_q <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (wr && !rst) mem[wptr[AW-1:0]] <= bus.rx_data;
    end

    assign bus.rd_data  = empty_w ? '0 : mem[rptr[AW-1:0]];
    assign bus.empty    = empty_w;
    assign bus.full     = full_w;
    assign bus.count    = count_q;
    assign bus.overflow = ovf_q;

`ifdef UART_RX_FIFO_ALMOST_FULL_EN
    logic af_q;

    // Compared on the next count so the flop lines up with count itself.
    always_ff @(posedge clk) begin
        if (rst) af_q <= 1'b0;
        else     af_q <= (32'(count_next) >= AF_LEVEL);
    end

    assign bus.almost_full = af_q;
`else
    logic unused_af_level;
    assign unused_af_level = (AF_LEVEL != 0);
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed self-checking bench for uart_rx_fifo (DEPTH=16, DATA_W=8).
module tb_uart_rx_fifo;

    logic clk;
    logic rst;
    int   checks;
    int   failures;
    logic [7:0] exp_q[$];

    uart_rx_fifo_if #(.DATA_W(8), .DEPTH(16)) bus ();

    uart_rx_fifo #(.DATA_W(8), .DEPTH(16), .AF_LEVEL(12)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push_byte(input logic [7:0] b);
        bus.rx_data = b;
        bus.rx_done = 1'b1;
        tick();
        bus.rx_done = 1'b0;
        tick();
    endtask

    task automatic pop_one();
        bus.rd_en = 1'b1;
        tick();
        bus.rd_en = 1'b0;
    endtask

    task automatic drain_check(input string tag);
        while (exp_q.size() > 0) begin
            check(tag, bus.rd_data, exp_q.pop_front());
            pop_one();
        end
        check({tag, "_empty"}, bus.empty, 1);
    endtask

    initial begin
        checks      = 0;
        failures    = 0;
        rst         = 1'b1;
        bus.rx_data = '0;
        bus.rx_done = 1'b0;
        bus.rd_en   = 1'b0;
        bus.clr_ovf = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        tick();

        check("reset_empty", bus.empty, 1);
        check("reset_full", bus.full, 0);
        check("reset_count", bus.count, 0);
        check("reset_overflow", bus.overflow, 0);
        check("reset_rd_data", bus.rd_data, 0);
`ifdef UART_RX_FIFO_ALMOST_FULL_EN
        check("reset_almost_full", bus.almost_full, 0);
`endif

        // Basic order
        push_byte(8'h55);
        push_byte(8'hA3);
        push_byte(8'h00);
        check("basic_count", bus.count, 3);
        check("basic_head", bus.rd_data, 8'h55);
        pop_one();
        check("basic_second", bus.rd_data, 8'hA3);
        pop_one();
        check("basic_third", bus.rd_data, 8'h00);
        check("basic_count1", bus.count, 1);
        pop_one();
        check("basic_empty", bus.empty, 1);

        // Long strobe: one entry for a five-clock rx_done
        bus.rx_data = 8'h7E;
        bus.rx_done = 1'b1;
        repeat (5) tick();
        bus.rx_done = 1'b0;
        tick();
        check("long_count", bus.count, 1);
        check("long_data", bus.rd_data, 8'h7E);
        pop_one();
        check("long_empty", bus.empty, 1);

        // Overflow: 17 bytes into 16 entries
        for (int i = 0; i < 16; i++) begin
            push_byte(8'(i));
            exp_q.push_back(8'(i));
        end
        check("ovf_full", bus.full, 1);
        check("ovf_count16", bus.count, 16);
        check("ovf_not_yet", bus.overflow, 0);
`ifdef UART_RX_FIFO_ALMOST_FULL_EN
        check("af_at_full", bus.almost_full, 1);
`endif
        push_byte(8'h10);
        check("ovf_set", bus.overflow, 1);
        check("ovf_count_held", bus.count, 16);
        check("ovf_head_kept", bus.rd_data, 8'h00);
        drain_check("ovf_drain");
        bus.rd_en = 1'b1;
        tick();
        bus.rd_en = 1'b0;
        check("rd_empty_count", bus.count, 0);
        check("ovf_sticky", bus.overflow, 1);
        bus.clr_ovf = 1'b1;
        tick();
        bus.clr_ovf = 1'b0;
        check("ovf_cleared", bus.overflow, 0);

        // Drop and clr_ovf together: drop wins
        for (int i = 0; i < 16; i++) push_byte(8'h40 + 8'(i));
        bus.rx_data = 8'hEE;
        bus.rx_done = 1'b1;
        bus.clr_ovf = 1'b1;
        tick();
        bus.rx_done = 1'b0;
        bus.clr_ovf = 1'b0;
        tick();
        check("ovf_drop_wins", bus.overflow, 1);
        bus.clr_ovf = 1'b1;
        tick();
        bus.clr_ovf = 1'b0;
        check("ovf_clr2", bus.overflow, 0);
        while (bus.count != 0 && checks < 1000) pop_one();
        check("flush_empty", bus.empty, 1);

        // Simultaneous push and pop at full
        for (int i = 0; i < 16; i++) begin
            push_byte(8'h20 + 8'(i));
            exp_q.push_back(8'h20 + 8'(i));
        end
        bus.rx_data = 8'hC4;
        bus.rx_done = 1'b1;
        bus.rd_en   = 1'b1;
        tick();
        bus.rx_done = 1'b0;
        bus.rd_en   = 1'b0;
        tick();
        void'(exp_q.pop_front());
        exp_q.push_back(8'hC4);
        check("simul_count", bus.count, 16);
        check("simul_overflow", bus.overflow, 0);
        check("simul_head", bus.rd_data, 8'h21);
        drain_check("simul_drain");

        // Empty with push and rd_en together: push wins, pop ignored
        bus.rx_data = 8'h99;
        bus.rx_done = 1'b1;
        bus.rd_en   = 1'b1;
        tick();
        bus.rx_done = 1'b0;
        bus.rd_en   = 1'b0;
        tick();
        check("empty_push_pop_count", bus.count, 1);
        check("empty_push_pop_data", bus.rd_data, 8'h99);
        pop_one();

        // Wrap: 40 random bytes, at most 3 outstanding
        for (int i = 0; i < 40; i++) begin
            logic [7:0] b;
            b = 8'($urandom_range(0, 255));
            push_byte(b);
            exp_q.push_back(b);
            if (exp_q.size() == 3 || $urandom_range(0, 1) == 1) begin
                check("wrap_data", bus.rd_data, exp_q.pop_front());
                pop_one();
            end
        end
        drain_check("wrap_drain");
        bus.rd_en = 1'b1;
        repeat (3) tick();
        bus.rd_en = 1'b0;
        check("wrap_idle_count", bus.count, 0);
        push_byte(8'h3C);
        check("wrap_after_idle", bus.rd_data, 8'h3C);
        pop_one();

        // Reset mid-stream with rx_done held high
        for (int i = 0; i < 16; i++) push_byte(8'h60 + 8'(i));
        push_byte(8'hFF);
        repeat (11) pop_one();
        check("rst_pre_count", bus.count, 5);
        check("rst_pre_ovf", bus.overflow, 1);
        bus.rx_data = 8'hAB;
        bus.rx_done = 1'b1;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_empty", bus.empty, 1);
        check("rst_count", bus.count, 0);
        check("rst_overflow", bus.overflow, 0);
        repeat (3) tick();
        check("rst_no_push_held", bus.count, 0);
        bus.rx_done = 1'b0;
        tick();
        push_byte(8'h5A);
        check("rst_recover_count", bus.count, 1);
        check("rst_recover_data", bus.rd_data, 8'h5A);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
- Buffers received bytes downstream of the UART receiver inside UART_top.
- Captures each byte from rx_data when rx_done rises.
- Stores bytes in a first-word-fall-through FIFO for the consumer (CPU/command logic).
- Flags overflow when bytes arrive with no free entry, so the receiver never back-pressures.

Parameters:
- DATA_W, 8, byte width; must match the receiver's rx_data.
- DEPTH, 16, number of entries; power of two, minimum 2.
- AF_LEVEL, 12, almost_full threshold; used only with the optional feature.

Ports:
- clk  input  1  system clock (100 MHz)
- rst  input  1  reset, synchronous, active-high
- rx_data  input  DATA_W  received byte from the UART receiver
- rx_done  input  1  receiver done strobe; may stay high for more than one clock
- rd_en  input  1  pop request from the consumer
- rd_data  output  DATA_W  head entry; valid whenever empty=0
- empty  output  1  FIFO holds no entries
- full  output  1  FIFO holds DEPTH entries
- count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH
- overflow  output  1  sticky: a byte was dropped
- clr_ovf  input  1  clears overflow
- almost_full  output  1  present only with the optional feature

Behaviour:
- Single clock domain: clk. rst is synchronous, active-high.
- Reset values: empty=1, full=0, count=0, overflow=0, rd_data=0, almost_full=0. Read/write pointers and the edge-detect register clear to 0.
- Reset mid-operation discards all stored data. The first cycle after reset sees no push, even if rx_done is held high.
- Push generation: push = rx_done & ~rx_done_q, where rx_done_q is a registered copy of rx_done.
  - Exactly one push per rx_done assertion, however long the pulse.
  - rx_data is sampled in the same cycle the rising edge is seen.
- Write: if push and (not full, or pop in the same cycle):
  - mem[wptr] <= rx_data; wptr increments, wrapping modulo DEPTH.
- Pop: pop = rd_en & ~empty. rptr increments, wrapping modulo DEPTH.
  - rd_en while empty is ignored; no state change and no error.
- rd_data is combinational from mem[rptr] (FWFT).
  - A written byte appears on rd_data one cycle after the push edge.
  - No latency through an empty FIFO beyond that one cycle.
- count update:
  - +1 on push-only.
  - -1 on pop-only.
  - Unchanged on simultaneous push and pop, or when neither occurs.
- Flags:
  - empty = (count==0); full = (count==DEPTH).
  - Pointers carry an extra wrap bit so that full and empty are distinguishable.
- Full with a simultaneous push and pop: both take effect; count stays DEPTH; no overflow.
- Full with push and no pop: the byte is dropped; overflow <= 1 on the next clock; stored contents are unchanged.
- overflow stays at 1 until clr_ovf=1 or rst.
  - If clr_ovf and a new drop occur in the same cycle, the drop wins and overflow stays 1.
- Empty with a simultaneous push and rd_en: the push succeeds and the pop is ignored, giving count=1.

Optional Feature:
- Macro: UART_RX_FIFO_ALMOST_FULL_EN.
- Defined:
  - almost_full port exists; almost_full = (count >= AF_LEVEL), registered.
  - Reset value is 0.
  - Intended for flow-control signalling upstream.
- Undefined:
  - Port and logic are absent; AF_LEVEL is ignored.
  - All other behaviour is identical.

Decomposition:
- Shared package uart_pkg holds:
  - UART_DATA_W = 8.
  - CLOCK_PER_BIT = 10416.
  - BAUD_RATE = 9600.
- A single sub-module, rise_edge_detect (1-bit input, 1-cycle registered compare), generates push from rx_done and is reusable for tx_start.
- Memory array, pointers and flags stay in uart_rx_fifo.

Test Plan:
- Basic order: drive bytes 0x55, 0xA3, 0x00 through the UART receiver at 9600 baud with no reads.
  - Required: count=3; rd_data=0x55.
  - Three rd_en pulses yield 0xA3 then 0x00, then empty=1.
- Long strobe: hold rx_done high for 5 cycles with rx_data=0x7E.
  - Required: exactly one entry, count=1.
- Overflow: push 17 bytes 0x00..0x10 into DEPTH=16 with no reads.
  - Required: full=1 after the 16th; overflow=1 after the 17th.
  - Draining 16 reads returns 0x00..0x0F; 0x10 is never seen.
  - clr_ovf pulse then gives overflow=0.
- Simultaneous at full: at count=16, push 0xC4 together with rd_en.
  - Required: count stays 16; overflow=0.
  - 0xC4 is read last after 16 pops.
- Wrap and empty: 40 push/pop pairs of random bytes, at most 3 outstanding.
  - Required: every byte matches in order.
  - rd_en while empty leaves count=0 and the pointers unchanged.
- Reset mid-stream: with count=5, assert rst for 1 cycle while rx_done is high.
  - Required: empty=1, count=0, overflow=0 next cycle; no push while rx_done stays high.
